gf2_poly_divider: RTL and testbench



---
 rtl/gf2_poly_divider_pkg.sv | 7 +
 rtl/gf2_poly_divider_deg.sv | 15 +
 rtl/gf2_poly_divider.sv | 79 +++++++
 tb/tb_gf2_poly_divider.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/gf2_poly_divider_pkg.sv
// gf2_poly_divider_pkg: shared FSM state encoding and default widths for the GF(2) divider
package gf2_poly_divider_pkg;
  localparam int DEF_DW = 64;
  localparam int DEF_VW = 32;
  localparam int DEF_CW = 7;
  typedef enum logic [1:0] {S_IDLE, S_DEG, S_DIV, S_DONE} state_t;
endpackage

// File: rtl/gf2_poly_divider_deg.sv
// gf2_deg_encoder: index of the highest set bit of i_vec (o_idx) and an all-zero flag (o_zero)
module gf2_deg_encoder #(
  parameter int W  = 32,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_zero
);
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < W; i++) o_idx = i_vec[i] ? IW'(i) : o_idx;
  end
  assign o_zero = ~|i_vec;
endmodule

// File: rtl/gf2_poly_divider.sv
// gf2_poly_divider: sequential GF(2) long divider, one quotient bit per clock; start/dividend/divisor in, busy/done/quotient/remainder/div_zero out
module gf2_poly_divider import gf2_poly_divider_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);
  localparam int IW = $clog2(VW);
  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_a, r_q;
  logic [VW-1:0] r_d, r_r;
  logic [IW-1:0] r_deg, w_deg;
  logic [CW-1:0] r_cnt;
  logic          r_dz, w_zero, w_bit;
  logic [VW:0]   w_t;
  gf2_deg_encoder #(.W(VW)) u_deg (.i_vec(r_d), .o_idx(w_deg), .o_zero(w_zero));
  // partial remainder stays below deg(D), so T[deg] is the only bit that can need cancelling
  assign w_t   = {r_r, r_a[DW-1]};
  assign w_bit = w_t[r_deg];
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = start ? S_DEG : S_IDLE;
      S_DEG:   w_state_nxt = w_zero ? S_DONE : S_DIV;
      S_DIV:   w_state_nxt = (r_cnt == CW'(1)) ? S_DONE : S_DIV;
      default: w_state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_r     <= '0;
      r_deg   <= '0;
      r_cnt   <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: if (start) begin
          r_a  <= dividend;
          r_d  <= divisor;
          r_r  <= '0;
          r_q  <= '0;
          r_dz <= 1'b0;
        end
        S_DEG: begin
          r_deg <= w_deg;
          r_cnt <= CW'(DW);
          r_dz  <= w_zero;
        end
        S_DIV: begin
          r_r   <= w_t[VW-1:0] ^ (w_bit ? r_d : '0);
          r_q   <= {r_q[DW-2:0], w_bit};
          r_a   <= r_a << 1;
          r_cnt <= r_cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end
  assign busy      = r_state != S_IDLE;
  assign done      = r_state == S_DONE;
  assign quotient  = r_q;
  assign remainder = r_r;
  assign div_zero  = r_dz;
endmodule

// File: tb/tb_gf2_poly_divider.sv
// tb_gf2_poly_divider: scoreboard bench for gf2_poly_divider with directed vectors and a property sweep
module tb_gf2_poly_divider;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [63:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_zero;
  logic [63:0] quotient;
  logic [31:0] remainder;
  int total = 0, bad = 0, cyc = 0, done_cnt = 0;
  typedef struct {
    logic        exact;
    logic [63:0] a;
    logic [31:0] b;
    logic [63:0] q;
    logic [31:0] r;
    logic        dz;
    int          t0;
    int          lat;
  } item_t;
  item_t sb[$];
  gf2_poly_divider dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic logic [95:0] clmul(input logic [63:0] a, input logic [31:0] b);
    logic [95:0] p = '0;
    for (int i = 0; i < 32; i++) if (b[i]) p = p ^ ({32'b0, a} << i);
    return p;
  endfunction
  function automatic int degf(input logic [31:0] v);
    int d = -1;
    for (int i = 0; i < 32; i++) if (v[i]) d = i;
    return d;
  endfunction
  always @(negedge clk) begin : mon
    item_t it;
    if (!rst && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want done=0");
      end else begin
        it = sb.pop_front();
        chk("latency", 96'(cyc - it.t0), 96'(it.lat));
        if (it.exact) begin
          chk("quotient", {32'b0, quotient}, {32'b0, it.q});
          chk("remainder", {64'b0, remainder}, {64'b0, it.r});
          chk("div_zero", {95'b0, div_zero}, {95'b0, it.dz});
        end else begin
          chk("reconstruct", clmul(quotient, it.b) ^ {64'b0, remainder}, {32'b0, it.a});
          chk("rem_deg", {95'b0, degf(remainder) < degf(it.b)}, 96'd1);
          chk("div_zero", {95'b0, div_zero}, 96'd0);
        end
      end
    end
  end
  task automatic do_op(input logic [63:0] a, input logic [31:0] b, input logic exact,
                       input logic [63:0] q, input logic [31:0] r, input logic dz);
    int    n = 0;
    item_t it;
    @(negedge clk);
    while (busy && n < 200) begin @(negedge clk); n++; end
    it.exact = exact; it.a = a; it.b = b; it.q = q; it.r = r; it.dz = dz;
    it.t0 = cyc; it.lat = dz ? 2 : 66;
    sb.push_back(it);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = ~a; divisor = ~b;
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout: got done=0 want done=1");
      sb.delete();
    end
  endtask
  initial begin
    int t0, dc;
    #1;
    chk("rst_busy", {95'b0, busy}, 96'd0);
    chk("rst_done", {95'b0, done}, 96'd0);
    chk("rst_quotient", {32'b0, quotient}, 96'd0);
    chk("rst_remainder", {64'b0, remainder}, 96'd0);
    chk("rst_div_zero", {95'b0, div_zero}, 96'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_op(64'h10, 32'h13, 1, 64'h1, 32'h3, 0);
    do_op(64'h7, 32'h3, 1, 64'h2, 32'h1, 0);
    do_op(64'h5, 32'h3, 1, 64'h3, 32'h0, 0);
    do_op(64'h2, 32'h13, 1, 64'h0, 32'h2, 0);
    do_op(64'hDEADBEEF, 32'h1, 1, 64'hDEADBEEF, 32'h0, 0);
    do_op(64'h8000_0000_0000_0000, 32'h3, 1, 64'h7FFF_FFFF_FFFF_FFFF, 32'h1, 0);
    do_op(64'hFFFF_FFFF_FFFF_FFFF, 32'h8000_0000, 1, 64'h1_FFFF_FFFF, 32'h7FFF_FFFF, 0);
    do_op(64'hABCD, 32'h0, 1, 64'h0, 32'h0, 1);
    do_op(64'h10, 32'h13, 1, 64'h1, 32'h3, 0);
    dc = done_cnt;
    start = 1'b1; dividend = 64'h5; divisor = 32'h3;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_done_ignored", {95'b0, busy}, 96'd0);
    @(negedge clk);
    t0 = cyc;
    dc = done_cnt;
    start = 1'b1; dividend = 64'hFEDC_BA98_7654_3210; divisor = 32'h13;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      start = ~i[0]; dividend = 64'(i); divisor = 32'h0;
      @(negedge clk);
    end
    start = 1'b0;
    while (cyc < t0 + 11) @(negedge clk);
    chk("busy_before_rst", {95'b0, busy}, 96'd1);
    chk("no_done_while_busy", 96'(done_cnt - dc), 96'd0);
    rst = 1'b1;
    #1;
    chk("abort_busy", {95'b0, busy}, 96'd0);
    chk("abort_done", {95'b0, done}, 96'd0);
    chk("abort_quotient", {32'b0, quotient}, 96'd0);
    chk("abort_remainder", {64'b0, remainder}, 96'd0);
    chk("abort_div_zero", {95'b0, div_zero}, 96'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    chk("no_done_after_abort", 96'(done_cnt - dc), 96'd0);
    do_op(64'h7, 32'h3, 1, 64'h2, 32'h1, 0);
    for (int k = 0; k < 1000; k++) begin
      logic [63:0] a;
      logic [31:0] b;
      a = {$urandom, $urandom};
      b = $urandom >> $urandom_range(31, 0);
      if (b == 0) b = 32'h1;
      do_op(a, b, 0, 64'h0, 32'h0, 0);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 96'(sb.size()), 96'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
